rotate_detect: RTL and testbench



---
 rtl/rotate_detect.sv | 125 ++++++++++++
 tb/tb_rotate_detect.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rotate_detect.sv
// rtl/rotate_detect.sv - iterative detector of the rotation mapping X onto Y; optional ROTATE_DETECT_BIDIR_EN
// Default build searches right rotations only; ROTATE_DETECT_BIDIR_EN adds a parallel left search.
module rotate_detect #(
  parameter int N = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [N-1:0]         i_x,
  input  logic [N-1:0]         i_y,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_found,
  output logic [$clog2(N)-1:0] o_amt,
  output logic                 o_dir
);

  localparam int AW = $clog2(N);
`ifdef ROTATE_DETECT_BIDIR_EN
  localparam logic [AW-1:0] LAST = AW'(N / 2);
`else
  localparam logic [AW-1:0] LAST = AW'(N - 1);
`endif

  typedef enum logic [1:0] {IDLE, SEARCH, REPORT} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [N-1:0]  r_wr;
  logic [N-1:0]  r_t;
  logic [AW-1:0] r_cnt;
  logic          r_found;
  logic [AW-1:0] r_amt;
  logic          r_dir;
  logic          w_hit_r;
  logic          w_hit_l;
  logic          w_stop;
  logic          w_accept;

  assign w_accept = (r_state == IDLE) && i_start;
  assign w_hit_r  = (r_wr == r_t);
  assign w_stop   = w_hit_r || w_hit_l || (r_cnt == LAST);

`ifdef ROTATE_DETECT_BIDIR_EN
  logic [N-1:0] r_wl;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wl <= '0;
    end else if (w_accept) begin
      r_wl <= i_x;
    end else if ((r_state == SEARCH) && !w_stop) begin
      r_wl <= {r_wl[N-2:0], r_wl[N-1]};
    end
  end

  assign w_hit_l = (r_wl == r_t);
`else
  assign w_hit_l = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = SEARCH;
      SEARCH:  if (w_stop) w_next = REPORT;
      REPORT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      SEARCH: o_busy = 1'b1;
      REPORT: begin
        o_busy = 1'b1;
        o_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr  <= '0;
      r_t   <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_wr  <= i_x;
      r_t   <= i_y;
      r_cnt <= '0;
    end else if ((r_state == SEARCH) && !w_stop) begin
      r_wr  <= {r_wr[0], r_wr[N-1:1]};
      r_cnt <= r_cnt + AW'(1);
    end
  end

  // Results persist through the next search and change only when it ends; right wins a tie.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_found <= 1'b0;
      r_amt   <= '0;
      r_dir   <= 1'b1;
    end else if ((r_state == SEARCH) && w_stop) begin
      r_found <= w_hit_r || w_hit_l;
      r_amt   <= (w_hit_r || w_hit_l) ? r_cnt : '0;
      r_dir   <= w_hit_r || !w_hit_l;
    end
  end

  assign o_found = r_found;
  assign o_amt   = r_amt;
  assign o_dir   = r_dir;

endmodule

// File: tb/tb_rotate_detect.sv
// tb/tb_rotate_detect.sv - directed table-driven bench for rotate_detect
module tb_rotate_detect;

  localparam int N  = 8;
  localparam int AW = $clog2(N);

  typedef struct {
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         f;
    int           amt;
    logic         dir;
    int           lat;
  } vec_t;

  logic          clk   = 1'b0;
  logic          rst   = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  x     = '0;
  logic [N-1:0]  y     = '0;
  logic          busy;
  logic          done;
  logic          found;
  logic [AW-1:0] amt;
  logic          dir;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic p_found = 1'b0;
  int   p_amt   = 0;
  logic p_dir   = 1'b1;
  vec_t tbl[12];

  rotate_detect #(.N(N)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_start (start),
    .i_x     (x),
    .i_y     (y),
    .o_busy  (busy),
    .o_done  (done),
    .o_found (found),
    .o_amt   (amt),
    .o_dir   (dir)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %0d, expected %0d", tag, what, act, exp);
    end
  endtask

  // Cycle 0 is the cycle START is driven; latency is the index of the first cycle with DONE high.
  task automatic run(input string tag, input logic [N-1:0] vx, input logic [N-1:0] vy,
                     input bit inject, input logic [N-1:0] vy2,
                     input logic ef, input int eamt, input logic edir, input int elat);
    int lat = 0;
    int nd  = 0;
    @(negedge clk);
    x = vx; y = vy; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check(tag, "busy_c1", busy, 1);
    check(tag, "held_found", found, p_found);
    check(tag, "held_amt", amt, p_amt);
    check(tag, "held_dir", dir, p_dir);
    for (int i = 1; i <= 14; i++) begin
      if (i > 1) @(negedge clk);
      if (done) begin
        nd++;
        if (lat == 0) begin
          lat = i;
          check(tag, "busy_at_done", busy, 1);
        end
      end
      if (lat != 0 && i == lat + 1) check(tag, "busy_after", busy, 0);
      if (inject && i == 2) begin start = 1'b1; y = vy2; end
      if (inject && i == 3) start = 1'b0;
    end
    check(tag, "latency", lat, elat);
    check(tag, "done_count", nd, 1);
    check(tag, "found", found, ef);
    check(tag, "amt", amt, eamt);
    check(tag, "dir", dir, edir);
    p_found = ef; p_amt = eamt; p_dir = edir;
  endtask

  initial begin
    int first;
    int second;
    int nd;

`ifdef ROTATE_DETECT_BIDIR_EN
    tbl[0]  = '{8'hE8, 8'h74, 1'b1, 1, 1'b1, 3};
    tbl[1]  = '{8'hE8, 8'hD1, 1'b1, 1, 1'b0, 3};
    tbl[2]  = '{8'hE8, 8'h01, 1'b0, 0, 1'b1, 6};
    tbl[3]  = '{8'h00, 8'h00, 1'b1, 0, 1'b1, 2};
    tbl[4]  = '{8'hFF, 8'hFF, 1'b1, 0, 1'b1, 2};
    tbl[5]  = '{8'hAA, 8'h55, 1'b1, 1, 1'b1, 3};
    tbl[6]  = '{8'hAA, 8'hAA, 1'b1, 0, 1'b1, 2};
    tbl[7]  = '{8'h01, 8'h10, 1'b1, 4, 1'b1, 6};
    tbl[8]  = '{8'h01, 8'h02, 1'b1, 1, 1'b0, 3};
    tbl[9]  = '{8'h01, 8'h08, 1'b1, 3, 1'b0, 5};
    tbl[10] = '{8'h03, 8'h81, 1'b1, 1, 1'b1, 3};
    tbl[11] = '{8'h0F, 8'h07, 1'b0, 0, 1'b1, 6};
`else
    tbl[0]  = '{8'hE8, 8'h74, 1'b1, 1, 1'b1, 3};
    tbl[1]  = '{8'hE8, 8'hD1, 1'b1, 7, 1'b1, 9};
    tbl[2]  = '{8'hE8, 8'h01, 1'b0, 0, 1'b1, 9};
    tbl[3]  = '{8'h00, 8'h00, 1'b1, 0, 1'b1, 2};
    tbl[4]  = '{8'hFF, 8'hFF, 1'b1, 0, 1'b1, 2};
    tbl[5]  = '{8'hAA, 8'h55, 1'b1, 1, 1'b1, 3};
    tbl[6]  = '{8'hAA, 8'hAA, 1'b1, 0, 1'b1, 2};
    tbl[7]  = '{8'h01, 8'h10, 1'b1, 4, 1'b1, 6};
    tbl[8]  = '{8'h01, 8'h02, 1'b1, 7, 1'b1, 9};
    tbl[9]  = '{8'h01, 8'h08, 1'b1, 5, 1'b1, 7};
    tbl[10] = '{8'h03, 8'h81, 1'b1, 1, 1'b1, 3};
    tbl[11] = '{8'h0F, 8'h07, 1'b0, 0, 1'b1, 9};
`endif

    #1 rst = 1'b1;
    #2;
    check("reset", "busy", busy, 0);
    check("reset", "done", done, 0);
    check("reset", "found", found, 0);
    check("reset", "amt", amt, 0);
    check("reset", "dir", dir, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, 1'b0, '0,
          tbl[i].f, tbl[i].amt, tbl[i].dir, tbl[i].lat);
    end

    // Second START mid-search targets an immediate match; it must be ignored.
    run("busy_start", 8'hE8, 8'hD1, 1'b1, 8'hE8, tbl[1].f, tbl[1].amt, tbl[1].dir, tbl[1].lat);

    // START held high: identity searches back to back, DONE at cycles 2 and 5.
    @(negedge clk);
    x = '0; y = '0; start = 1'b1;
    first = 0; second = 0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (done) begin
        if (first == 0) first = i;
        else if (second == 0) second = i;
      end
    end
    start = 1'b0;
    check("held_start", "first_done", first, 2);
    check("held_start", "second_done", second, 5);
    repeat (4) @(negedge clk);
    p_found = 1'b1; p_amt = 0; p_dir = 1'b1;

    // Asynchronous reset in the middle of a search, after a non-default result.
    run("pre_reset", 8'h01, 8'h10, 1'b0, '0, 1'b1, 4, 1'b1, 6);
    @(negedge clk);
    x = 8'hE8; y = 8'hD1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("mid_reset", "busy_before", busy, 1);
    #1 rst = 1'b1;
    #1;
    check("mid_reset", "busy", busy, 0);
    check("mid_reset", "done", done, 0);
    check("mid_reset", "found", found, 0);
    check("mid_reset", "amt", amt, 0);
    check("mid_reset", "dir", dir, 1);
    @(negedge clk);
    rst = 1'b0;
    p_found = 1'b0; p_amt = 0; p_dir = 1'b1;
    nd = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("mid_reset", "no_done", nd, 0);
    run("after_reset", 8'hE8, 8'hD1, 1'b0, '0, tbl[1].f, tbl[1].amt, tbl[1].dir, tbl[1].lat);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
